cfg_reg_bank: RTL and testbench
===============================

Name: cfg_reg_bank

Overview:
- Register-side consumer of the AXI-to-register bridge's reg_* request interface.
- Decodes host write/read requests into 16 config registers (cfg) plus a simple-dual-port parameter RAM.
- Presents the config registers to the accelerator core as a flat vector.
- Gives the core a hardware write port into cfg (status/done words) and a priority read port into the RAM.

Parameters:
AXI_WIDTH, 32, data width of registers, RAM words and reg_* data.
AXI_ADDR_WIDTH, 32, byte address width of reg_* addresses.
CONFIG_BASEADDR, 32'hA0000000, byte address of cfg[0].
N_CFG, 16, number of config registers; the RAM starts at word offset N_CFG.
RAM_DEPTH, 1024, RAM words.
RAM_AW, $clog2(RAM_DEPTH), RAM word address width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
reg_wr_en  in  1  host write request, one-cycle pulse
reg_wr_addr  in  AXI_ADDR_WIDTH  host write byte address
reg_wr_data  in  AXI_WIDTH  host write data
reg_wr_ack  out  1  write done, one-cycle pulse
reg_rd_en  in  1  host read request, one-cycle pulse
reg_rd_addr  in  AXI_ADDR_WIDTH  host read byte address
reg_rd_data  out  AXI_WIDTH  read data, valid with reg_rd_ack
reg_rd_ack  out  1  read done, one-cycle pulse
cfg_o  out  N_CFG*AXI_WIDTH  cfg[i] at bits [i*AXI_WIDTH +: AXI_WIDTH]
hw_wr_en  in  1  core write to cfg
hw_wr_idx  in  $clog2(N_CFG)  core write index
hw_wr_data  in  AXI_WIDTH  core write data
core_rd_en  in  1  core RAM read
core_rd_addr  in  RAM_AW  core RAM word address
core_rd_data  out  AXI_WIDTH  RAM data, one cycle after core_rd_en

Behaviour:
- Clocking and reset: all state on posedge clk; asynchronous active-high rst.
- Reset values: cfg all 0; reg_wr_ack, reg_rd_ack, reg_rd_data, core_rd_data all 0; read FSM to IDLE. RAM contents are not reset.
- Decode: offset = (addr - CONFIG_BASEADDR) >> 2, computed in AXI_ADDR_WIDTH bits, unsigned.
  - offset < N_CFG: cfg[offset].
  - N_CFG <= offset < N_CFG+RAM_DEPTH: RAM[offset-N_CFG].
  - Anything else, including addr < base (wraps large): out of range.
- Write path: reg_wr_en registers the decoded write. reg_wr_ack pulses the following cycle. The cfg/RAM update is visible from that same cycle.
  - Out-of-range writes are dropped but still acked.
  - The host never issues a new write before the ack.
- hw_wr_en writes cfg[hw_wr_idx] at the next edge. If host and hw write the same cfg index in the same cycle, hw wins; the host write is still acked.
- Read FSM states:
  - IDLE. On reg_rd_en:
    - cfg hit: capture cfg, go to ACK.
    - Out of range: capture 0, go to ACK.
    - RAM hit: latch address, go to RAM_REQ.
  - RAM_REQ: issue a RAM read only if core_rd_en is low; otherwise stay (the core has priority, no starvation limit). Then go to RAM_WAIT.
  - RAM_WAIT: capture RAM output into reg_rd_data, go to ACK.
  - ACK: reg_rd_ack=1 for exactly one cycle, then IDLE.
- Read latency (reg_rd_en to reg_rd_ack): cfg/out-of-range = 2 cycles; RAM = 3 cycles with no core contention, +1 per stalled cycle.
- reg_rd_data holds its last value until the next capture.
- RAM has one write port (host) and one read port (core or host), read-first. A same-cycle write and read of the same word returns the old data.
- The cfg read capture samples the pre-write value when the host write and read target the same word in the same cycle.
- Write and read paths are independent; both acks may pulse in the same cycle.
- core_rd_data: registered RAM output, 1-cycle latency. It holds its value when core_rd_en is low.
- rst mid-read: FSM returns to IDLE and the pending read is never acked. The host bridge is reset by the same rst.

Decomposition:
- Shared package (cfg_pkg):
  - Constants N_CFG and CONFIG_BASEADDR.
  - enum rd_state_t {IDLE, RAM_REQ, RAM_WAIT, ACK}.
  - Function addr_to_offset().
- One sub-module, sdp_ram: array RAM, single write port, single registered read port, read-first, no reset.

Test Plan:
- Reset, write 0x12345678 to BASE+0x08 -> reg_wr_ack 1 cycle later; cfg_o[2] = 0x12345678; read BASE+0x08 returns it with ack 2 cycles after en.
- Write 0xCAFEF00D to BASE+0x40 (RAM[0]), read back -> 0xCAFEF00D with ack 3 cycles after en; core_rd_en addr 0 returns the same value 1 cycle later.
- Host RAM read while core_rd_en held high 4 cycles -> reg_rd_ack delayed to 7 cycles after en, correct data.
- Same cycle: host writes cfg[5]=0x1, hw writes cfg[5]=0x2 -> cfg_o[5] = 0x2, reg_wr_ack still pulses.
- Write/read to BASE+4*(16+RAM_DEPTH) and to BASE-4 -> writes acked with no state change; reads return 0.
- Assert rst during RAM_WAIT -> no reg_rd_ack; cfg_o all 0; next read completes normally.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared constants, read-FSM state type and address decode helper for cfg_reg_bank.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package cfg_pkg;

  localparam int AXI_WIDTH      = 32;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int N_CFG          = 16;
  localparam logic [AXI_ADDR_WIDTH-1:0] CONFIG_BASEADDR = 32'hA000_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_REQ  = 2'd1,
    RAM_WAIT = 2'd2,
    ACK      = 2'd3
  } rd_state_t;

  // Word offset from the bank base. Addresses below the base wrap to huge
  // offsets, so they fall out of range without a separate check.
  function automatic logic [AXI_ADDR_WIDTH-1:0] addr_to_offset(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [AXI_ADDR_WIDTH-1:0] base
  );
    logic [AXI_ADDR_WIDTH-1:0] diff;
    diff = addr - base;
    return diff >> 2;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple-dual-port RAM: one write port, one registered read port, read-first.
// Latency: read data valid one cycle after re; write visible to reads issued from the next cycle.
// Backpressure: none; ports accept a request every cycle. Contents are not reset.
module sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read and write in one block; non-blocking update gives old data on a same-word collision.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[raddr];
    end
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cfg_reg_bank.sv
// Host-facing config register bank (16 cfg words + parameter RAM) with core write/read side ports.
// Latency: write ack 1 cycle; read ack 2 cycles (cfg/out-of-range), 3 cycles (RAM) +1 per core-stalled cycle.
// Backpressure: core RAM reads always win the shared read port; the host read waits with no starvation limit.
module cfg_reg_bank #(
  parameter int AXI_WIDTH      = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] CONFIG_BASEADDR = 32'hA000_0000,
  parameter int N_CFG          = 16,
  parameter int RAM_DEPTH      = 1024,
  parameter int RAM_AW         = $clog2(RAM_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reg_wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0]    reg_wr_addr,
  input  logic [AXI_WIDTH-1:0]         reg_wr_data,
  output logic                         reg_wr_ack,
  input  logic                         reg_rd_en,
  input  logic [AXI_ADDR_WIDTH-1:0]    reg_rd_addr,
  output logic [AXI_WIDTH-1:0]         reg_rd_data,
  output logic                         reg_rd_ack,
  output logic [N_CFG*AXI_WIDTH-1:0]   cfg_o,
  input  logic                         hw_wr_en,
  input  logic [$clog2(N_CFG)-1:0]     hw_wr_idx,
  input  logic [AXI_WIDTH-1:0]         hw_wr_data,
  input  logic                         core_rd_en,
  input  logic [RAM_AW-1:0]            core_rd_addr,
  output logic [AXI_WIDTH-1:0]         core_rd_data
);
  import cfg_pkg::*;

  localparam int CFG_IW = $clog2(N_CFG);
  localparam logic [AXI_ADDR_WIDTH-1:0] CFG_END = AXI_ADDR_WIDTH'(N_CFG);
  localparam logic [AXI_ADDR_WIDTH-1:0] RAM_END = AXI_ADDR_WIDTH'(N_CFG + RAM_DEPTH);

  // ---------------- address decode ----------------
  logic [AXI_ADDR_WIDTH-1:0] wr_off, rd_off;
  logic                      wr_cfg_hit, wr_ram_hit, rd_cfg_hit, rd_ram_hit;
  logic [CFG_IW-1:0]         wr_cfg_idx, rd_cfg_idx;
  logic [RAM_AW-1:0]         wr_ram_idx, rd_ram_idx;

  // Decode both host ports into cfg hit / RAM hit / out-of-range.
  always_comb begin
    wr_off     = addr_to_offset(reg_wr_addr, CONFIG_BASEADDR);
    rd_off     = addr_to_offset(reg_rd_addr, CONFIG_BASEADDR);
    wr_cfg_hit = (wr_off < CFG_END);
    rd_cfg_hit = (rd_off < CFG_END);
    wr_ram_hit = !wr_cfg_hit && (wr_off < RAM_END);
    rd_ram_hit = !rd_cfg_hit && (rd_off < RAM_END);
    wr_cfg_idx = CFG_IW'(wr_off);
    rd_cfg_idx = CFG_IW'(rd_off);
    wr_ram_idx = RAM_AW'(wr_off - CFG_END);
    rd_ram_idx = RAM_AW'(rd_off - CFG_END);
  end

  // ---------------- cfg registers and write path ----------------
  logic [N_CFG-1:0][AXI_WIDTH-1:0] cfg_q, cfg_d;
  logic                            wr_ack_q, wr_ack_d;

  // Host write first, core write second so the core wins a same-index collision.
  always_comb begin
    cfg_d    = cfg_q;
    wr_ack_d = reg_wr_en;
    if (reg_wr_en && wr_cfg_hit) begin
      cfg_d[wr_cfg_idx] = reg_wr_data;
    end
    if (hw_wr_en) begin
      cfg_d[hw_wr_idx] = hw_wr_data;
    end
  end

  // Register cfg contents and the write ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q    <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign cfg_o      = cfg_q;
  assign reg_wr_ack = wr_ack_q;

  // ---------------- RAM and shared read port ----------------
  rd_state_t          state_q;
  logic [RAM_AW-1:0]  rd_addr_q;
  logic [AXI_WIDTH-1:0] rd_data_q;
  logic               rd_ack_q;
  logic               host_re, ram_re;
  logic [RAM_AW-1:0]  ram_raddr;
  logic [AXI_WIDTH-1:0] ram_rdata;

  // A host RAM read goes straight to the port from IDLE when the core is quiet;
  // otherwise it parks in RAM_REQ with the latched address until the port frees up.
  always_comb begin
    host_re   = !core_rd_en &&
                (((state_q == IDLE) && reg_rd_en && rd_ram_hit) || (state_q == RAM_REQ));
    ram_re    = core_rd_en || host_re;
    ram_raddr = core_rd_en ? core_rd_addr :
                ((state_q == IDLE) ? rd_ram_idx : rd_addr_q);
  end

  sdp_ram #(
    .WIDTH (AXI_WIDTH),
    .DEPTH (RAM_DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (reg_wr_en && wr_ram_hit),
    .waddr (wr_ram_idx),
    .wdata (reg_wr_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // ---------------- host read FSM ----------------
  // Host read sequencing with registered data and ack; ack follows the ACK state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
    end else begin
      rd_ack_q <= (state_q == ACK);
      case (state_q)
        IDLE: begin
          if (reg_rd_en) begin
            if (rd_cfg_hit) begin
              rd_data_q <= cfg_q[rd_cfg_idx];
              state_q   <= ACK;
            end else if (rd_ram_hit) begin
              rd_addr_q <= rd_ram_idx;
              state_q   <= core_rd_en ? RAM_REQ : RAM_WAIT;
            end else begin
              rd_data_q <= '0;
              state_q   <= ACK;
            end
          end
        end
        RAM_REQ: begin
          if (!core_rd_en) begin
            state_q <= RAM_WAIT;
          end
        end
        RAM_WAIT: begin
          rd_data_q <= ram_rdata;
          state_q   <= ACK;
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign reg_rd_data = rd_data_q;
  assign reg_rd_ack  = rd_ack_q;

  // ---------------- core read data ----------------
  logic                 core_sel_q, core_sel_d;
  logic [AXI_WIDTH-1:0] core_hold_q, core_hold_d;

  // Remember the last core read result so host reads through the shared port do not disturb it.
  always_comb begin
    core_sel_d  = core_rd_en;
    core_hold_d = core_sel_q ? ram_rdata : core_hold_q;
  end

  // Register core read select and held data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_sel_q  <= 1'b0;
      core_hold_q <= '0;
    end else begin
      core_sel_q  <= core_sel_d;
      core_hold_q <= core_hold_d;
    end
  end

  assign core_rd_data = core_sel_q ? ram_rdata : core_hold_q;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Directed bench for cfg_reg_bank: host writes/reads, core side ports, collisions, reset mid-read.
module tb_cfg_reg_bank;

  localparam logic [31:0] BASE = 32'hA000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         reg_wr_en = 1'b0;
  logic [31:0]  reg_wr_addr = '0;
  logic [31:0]  reg_wr_data = '0;
  logic         reg_wr_ack;
  logic         reg_rd_en = 1'b0;
  logic [31:0]  reg_rd_addr = '0;
  logic [31:0]  reg_rd_data;
  logic         reg_rd_ack;
  logic [511:0] cfg_o;
  logic         hw_wr_en = 1'b0;
  logic [3:0]   hw_wr_idx = '0;
  logic [31:0]  hw_wr_data = '0;
  logic         core_rd_en = 1'b0;
  logic [9:0]   core_rd_addr = '0;
  logic [31:0]  core_rd_data;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_cfg [16];

  cfg_reg_bank dut (
    .clk          (clk),
    .rst          (rst),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_ack   (reg_wr_ack),
    .reg_rd_en    (reg_rd_en),
    .reg_rd_addr  (reg_rd_addr),
    .reg_rd_data  (reg_rd_data),
    .reg_rd_ack   (reg_rd_ack),
    .cfg_o        (cfg_o),
    .hw_wr_en     (hw_wr_en),
    .hw_wr_idx    (hw_wr_idx),
    .hw_wr_data   (hw_wr_data),
    .core_rd_en   (core_rd_en),
    .core_rd_addr (core_rd_addr),
    .core_rd_data (core_rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_cfg(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_cfg%0d", tag, i), cfg_o[i*32 +: 32], exp_cfg[i]);
    end
  endtask

  task automatic host_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    reg_wr_addr = addr;
    reg_wr_data = data;
    reg_wr_en   = 1'b1;
    step();
    reg_wr_en   = 1'b0;
    chk({tag, "_wack"}, 32'(reg_wr_ack), 32'd1);
  endtask

  // Read with expected ack latency; core_rd_en is held high for the first 'hold' cycles.
  task automatic host_read(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                           input int lat, input int hold);
    reg_rd_addr = addr;
    reg_rd_en   = 1'b1;
    core_rd_en  = (hold > 0);
    for (int k = 1; k <= lat; k++) begin
      step();
      reg_rd_en  = 1'b0;
      core_rd_en = (k < hold);
      if (k < lat) begin
        chk($sformatf("%s_noack_c%0d", tag, k), 32'(reg_rd_ack), 32'd0);
      end else begin
        chk({tag, "_rack"}, 32'(reg_rd_ack), 32'd1);
        chk({tag, "_rdata"}, reg_rd_data, exp);
      end
    end
    step();
    chk({tag, "_rack_drop"}, 32'(reg_rd_ack), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) exp_cfg[i] = 32'h0;

    // Reset state
    step();
    step();
    chk("rst_wack", 32'(reg_wr_ack), 32'd0);
    chk("rst_rack", 32'(reg_rd_ack), 32'd0);
    chk("rst_rdata", reg_rd_data, 32'h0);
    chk("rst_core", core_rd_data, 32'h0);
    check_cfg("rst");
    rst = 1'b0;
    step();

    // cfg write / read
    host_write("cfg2", BASE + 32'h08, 32'h1234_5678);
    exp_cfg[2] = 32'h1234_5678;
    chk("cfg2_vis", cfg_o[2*32 +: 32], 32'h1234_5678);
    step();
    chk("cfg2_wack_drop", 32'(reg_wr_ack), 32'd0);
    host_read("cfg2", BASE + 32'h08, 32'h1234_5678, 2, 0);

    // RAM[0] write / read, then core read
    host_write("ram0", BASE + 32'h40, 32'hCAFE_F00D);
    host_read("ram0", BASE + 32'h40, 32'hCAFE_F00D, 3, 0);
    core_rd_addr = 10'd0;
    core_rd_en   = 1'b1;
    step();
    core_rd_en   = 1'b0;
    chk("core_ram0", core_rd_data, 32'hCAFE_F00D);
    step();
    chk("core_hold", core_rd_data, 32'hCAFE_F00D);

    // Host RAM read stalled by the core for 4 cycles
    host_write("ram5", BASE + 32'h54, 32'hDEAD_BEEF);
    core_rd_addr = 10'd0;
    host_read("ram5_stall", BASE + 32'h54, 32'hDEAD_BEEF, 7, 4);
    chk("core_hold_after_host", core_rd_data, 32'hCAFE_F00D);

    // Host and core write the same cfg index together
    reg_wr_addr = BASE + 32'h14;
    reg_wr_data = 32'h1;
    reg_wr_en   = 1'b1;
    hw_wr_en    = 1'b1;
    hw_wr_idx   = 4'd5;
    hw_wr_data  = 32'h2;
    step();
    reg_wr_en   = 1'b0;
    hw_wr_en    = 1'b0;
    exp_cfg[5]  = 32'h2;
    chk("coll_wack", 32'(reg_wr_ack), 32'd1);
    chk("coll_cfg5", cfg_o[5*32 +: 32], 32'h2);

    // Core write alone
    hw_wr_en   = 1'b1;
    hw_wr_idx  = 4'd15;
    hw_wr_data = 32'h0000_0777;
    step();
    hw_wr_en   = 1'b0;
    exp_cfg[15] = 32'h0000_0777;
    chk("hw_cfg15", cfg_o[15*32 +: 32], 32'h0000_0777);

    // Out-of-range above RAM and below base
    host_write("oor_hi", BASE + 32'h0000_1040, 32'hFFFF_FFFF);
    host_write("oor_lo", BASE - 32'h4, 32'h5555_5555);
    check_cfg("oor");
    host_read("oor_hi", BASE + 32'h0000_1040, 32'h0, 2, 0);
    host_read("ram0_intact", BASE + 32'h40, 32'hCAFE_F00D, 3, 0);
    host_read("oor_lo", BASE - 32'h4, 32'h0, 2, 0);

    // Same-cycle write and read of cfg[3] returns the old value
    reg_wr_addr = BASE + 32'h0C;
    reg_wr_data = 32'h0000_AAAA;
    reg_wr_en   = 1'b1;
    reg_rd_addr = BASE + 32'h0C;
    reg_rd_en   = 1'b1;
    step();
    reg_wr_en   = 1'b0;
    reg_rd_en   = 1'b0;
    exp_cfg[3]  = 32'h0000_AAAA;
    chk("rw3_wack", 32'(reg_wr_ack), 32'd1);
    chk("rw3_noack", 32'(reg_rd_ack), 32'd0);
    step();
    chk("rw3_rack", 32'(reg_rd_ack), 32'd1);
    chk("rw3_old", reg_rd_data, 32'h0);
    step();
    host_read("rw3_new", BASE + 32'h0C, 32'h0000_AAAA, 2, 0);

    // Reset while the RAM read is in RAM_WAIT
    reg_rd_addr = BASE + 32'h54;
    reg_rd_en   = 1'b1;
    step();
    reg_rd_en   = 1'b0;
    rst         = 1'b1;
    for (int i = 0; i < 16; i++) exp_cfg[i] = 32'h0;
    chk("rstmid_ack0", 32'(reg_rd_ack), 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rstmid_noack%0d", k), 32'(reg_rd_ack), 32'd0);
    end
    chk("rstmid_rdata", reg_rd_data, 32'h0);
    check_cfg("rstmid");
    host_read("after_rst", BASE + 32'h54, 32'hDEAD_BEEF, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
